axis_result_serializer: RTL

AXIS_RESULT_SERIALIZER -- requirements
Module: axis_result_serializer

---
 rtl/axis_result_serializer_pkg.sv | 16 +
 rtl/axis_lane_buffer.sv | 41 ++++
 rtl/axis_result_serializer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/axis_result_serializer_pkg.sv
// Shared definitions for the result serializer: drain FSM states and the
// helper that sizes the lane index.
package axis_result_serializer_pkg;

  typedef enum logic {
    COLLECT,
    DRAIN
  } state_t;

  // Width of the lane index; never narrower than one bit so a single-lane
  // build still has a legal counter.
  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/axis_lane_buffer.sv
// One-entry skid buffer for a single result lane. Holds one word plus its
// last/user sideband until the serializer clears the whole row.
module axis_lane_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic                  clear,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic [USER_WIDTH-1:0] user
);

  // Ready is held low while reset is asserted so nothing is accepted mid-reset.
  assign s_tready = rst && !full;

  // Capture one beat when empty; the row clear frees the slot for the next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
      data <= '0;
      last <= 1'b0;
      user <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      full <= 1'b1;
      data <= s_tdata;
      last <= s_tlast;
      user <= s_tuser;
    end
  end

endmodule

// File: rtl/axis_result_serializer.sv
// Collects one result word per array column and replays the row as a single
// AXI-Stream, lane 0 first.
// Optional build macro: AXIS_RESULT_SERIALIZER_LANE_TAG_EN overwrites the low
// lane-index bits of m_axis_tuser with the lane number of each beat.
module axis_result_serializer
  import axis_result_serializer_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LANES-1:0]            s_axis_tvalid,
  output logic [LANES-1:0]            s_axis_tready,
  input  logic [LANES-1:0]            s_axis_tlast,
  input  logic [LANES*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [ID_WIDTH-1:0]         m_axis_tid,
  output logic [DEST_WIDTH-1:0]       m_axis_tdest,
  output logic [USER_WIDTH-1:0]       m_axis_tuser,
  input  logic [ID_WIDTH-1:0]         cfg_id,
  input  logic [DEST_WIDTH-1:0]       cfg_dest,
  output logic                        err_tlast_mismatch
);

  localparam int                   LANE_BITS = lane_bits(LANES);
  localparam logic [LANE_BITS-1:0] LAST_IDX  = LANE_BITS'(LANES - 1);

  state_t                 state;
  logic [LANE_BITS-1:0]   cnt;
  logic [LANES-1:0]       full;
  logic [LANES-1:0]       buf_last;
  logic [DATA_WIDTH-1:0]  buf_data [LANES];
  logic [USER_WIDTH-1:0]  buf_user [LANES];
  logic [LANES-1:0]       full_next;
  logic [LANES-1:0]       last_next;
  logic                   row_full;
  logic                   lasts_agree;
  logic                   drain_active;
  logic                   drain_fire;
  logic                   row_done;
  logic [USER_WIDTH-1:0]  user_sel;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    axis_lane_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .USER_WIDTH(USER_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .s_tdata (s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]),
      .s_tvalid(s_axis_tvalid[k]),
      .s_tready(s_axis_tready[k]),
      .s_tlast (s_axis_tlast[k]),
      .s_tuser (s_axis_tuser[k*USER_WIDTH +: USER_WIDTH]),
      .clear   (row_done),
      .full    (full[k]),
      .data    (buf_data[k]),
      .last    (buf_last[k]),
      .user    (buf_user[k])
    );
  end

  // Look one edge ahead so the drain starts on the same edge the last lane
  // captures, giving one cycle from final handshake to m_axis_tvalid.
  always_comb begin
    full_next = full;
    last_next = buf_last;
    for (int k = 0; k < LANES; k++) begin
      if (s_axis_tvalid[k] && s_axis_tready[k]) begin
        full_next[k] = 1'b1;
        last_next[k] = s_axis_tlast[k];
      end
    end
    row_full    = &full_next;
    lasts_agree = (&last_next) || !(|last_next);
  end

  // Output is gated by reset so a beat cannot complete while reset is low.
  assign drain_active  = (state == DRAIN) && rst;
  assign drain_fire    = drain_active && m_axis_tready;
  assign row_done      = drain_fire && (cnt == LAST_IDX);
  assign m_axis_tvalid = drain_active;
  assign m_axis_tid    = cfg_id;
  assign m_axis_tdest  = cfg_dest;

  // Select the buffered lane addressed by cnt; outputs are zero while collecting.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tuser = '0;
    m_axis_tlast = 1'b0;
    user_sel     = buf_user[cnt];
`ifdef AXIS_RESULT_SERIALIZER_LANE_TAG_EN
    user_sel[LANE_BITS-1:0] = cnt;
`endif
    if (drain_active) begin
      m_axis_tdata = buf_data[cnt];
      m_axis_tuser = user_sel;
      m_axis_tlast = (cnt == LAST_IDX) && buf_last[0];
    end
  end

  // Row sequencer: wait for every lane, then walk cnt across the lanes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= COLLECT;
      cnt                <= '0;
      err_tlast_mismatch <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (row_full) begin
            state <= DRAIN;
            cnt   <= '0;
            if (!lasts_agree) begin
              err_tlast_mismatch <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            if (cnt == LAST_IDX) begin
              state <= COLLECT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + LANE_BITS'(1);
            end
          end
        end
        default: begin
          state <= COLLECT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
